// File: rtl/count_min_sec_pkg.sv
// Shared BCD limits, default terminal values and the packed time payload
// used by the minute/second counter and its lap capture.
package count_min_sec_pkg;

  localparam int unsigned BCD_W   = 8;
  localparam int unsigned DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;
  localparam logic [DIGIT_W-1:0] TENS_MAX  = 4'd5;

  localparam logic [BCD_W-1:0] MIN_MAX_DEF = 8'h59;
  localparam logic [BCD_W-1:0] SEC_MAX_DEF = 8'h59;

  typedef struct packed {
    logic [BCD_W-1:0] m;
    logic [BCD_W-1:0] s;
    logic [BCD_W-1:0] cs;
  } bcd_time_t;

  // One BCD step; digits outside 0-9 fall back to 0 so a corrupted value heals.
  function automatic logic [BCD_W-1:0] bcd_step(input logic [BCD_W-1:0] v);
    logic [DIGIT_W-1:0] units;
    logic [DIGIT_W-1:0] tens;
    units = v[DIGIT_W-1:0];
    tens  = v[BCD_W-1:DIGIT_W];
    if (tens > DIGIT_MAX) begin
      tens = '0;
    end
    if (units >= DIGIT_MAX) begin
      units = '0;
      tens  = (tens >= TENS_MAX) ? '0 : DIGIT_W'(tens + DIGIT_W'(1));
    end else begin
      units = DIGIT_W'(units + DIGIT_W'(1));
    end
    return {tens, units};
  endfunction

endpackage

// File: rtl/bcd_mod_cnt.sv
// Two-digit BCD modulo counter: wraps to 00 after MAX, carry_c flags the wrap.
module bcd_mod_cnt
  import count_min_sec_pkg::*;
#(
  parameter logic [BCD_W-1:0] MAX = SEC_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] cnt,
  output logic             carry_c
);

  logic [BCD_W-1:0] cnt_q;
  logic [BCD_W-1:0] cnt_d;

  assign carry_c = inc & (cnt_q == MAX);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = (cnt_q == MAX) ? '0 : bcd_step(cnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/count_min_sec.sv
// Stopwatch minutes/seconds stage fed by a centisecond counter, with a
// lap/hold capture that freezes the display while the live count runs on.
module count_min_sec
  import count_min_sec_pkg::*;
#(
  parameter logic [BCD_W-1:0] MIN_MAX = MIN_MAX_DEF,
  parameter logic [BCD_W-1:0] SEC_MAX = SEC_MAX_DEF
) (
  input  logic             clk_100Hz,
  input  logic             rst_n,
  input  logic             clr_flag,
  input  logic             en,
  input  logic             carry_1s,
  input  logic [BCD_W-1:0] cnt_cs,
  input  logic             lap_key,
  output logic [BCD_W-1:0] cnt_s,
  output logic [BCD_W-1:0] cnt_m,
  output logic             carry_1h,
  output logic [BCD_W-1:0] disp_m,
  output logic [BCD_W-1:0] disp_s,
  output logic [BCD_W-1:0] disp_cs,
  output logic             hold
);

  logic adv_s_c;
  logic carry_s_c;
  logic carry_m_c;

  assign adv_s_c = en & carry_1s;

  bcd_mod_cnt #(.MAX(SEC_MAX)) u_sec (
    .clk     (clk_100Hz),
    .rst_n   (rst_n),
    .clr     (clr_flag),
    .inc     (adv_s_c),
    .cnt     (cnt_s),
    .carry_c (carry_s_c)
  );

  bcd_mod_cnt #(.MAX(MIN_MAX)) u_min (
    .clk     (clk_100Hz),
    .rst_n   (rst_n),
    .clr     (clr_flag),
    .inc     (carry_s_c),
    .cnt     (cnt_m),
    .carry_c (carry_m_c)
  );

  assign carry_1h = rst_n & carry_m_c;

  logic      lap_key_q, lap_key_d;
  logic      hold_q, hold_d;
  bcd_time_t lap_q, lap_d;
  bcd_time_t live_c;
  bcd_time_t shown_c;
  logic      lap_evt_c;

  assign live_c    = {cnt_m, cnt_s, cnt_cs};
  assign lap_evt_c = lap_key & ~lap_key_q;

  // Each key rising edge toggles hold; only the entry into hold captures.
  always_comb begin
    lap_key_d = lap_key;
    hold_d    = hold_q;
    lap_d     = lap_q;
    if (clr_flag) begin
      hold_d = 1'b0;
      lap_d  = '0;
    end else if (lap_evt_c) begin
      hold_d = ~hold_q;
      if (!hold_q) begin
        lap_d = live_c;
      end
    end
  end

  always_ff @(posedge clk_100Hz or negedge rst_n) begin
    if (!rst_n) begin
      lap_key_q <= 1'b0;
      hold_q    <= 1'b0;
      lap_q     <= '0;
    end else begin
      lap_key_q <= lap_key_d;
      hold_q    <= hold_d;
      lap_q     <= lap_d;
    end
  end

  // Display is forced to zero in reset since cnt_cs comes from outside.
  assign shown_c = hold_q ? lap_q : live_c;
  assign disp_m  = rst_n ? shown_c.m  : '0;
  assign disp_s  = rst_n ? shown_c.s  : '0;
  assign disp_cs = rst_n ? shown_c.cs : '0;
  assign hold    = hold_q;

endmodule

// File: doc/count_min_sec.md
COUNT_MIN_SEC -- requirements
Module: count_min_sec

Interface
REQ-001 The module SHALL have the parameter MIN_MAX, default 8'h59, meaning the BCD terminal value of the minute count.
REQ-002 The module SHALL have the parameter SEC_MAX, default 8'h59, meaning the BCD terminal value of the second count.
REQ-003 The module SHALL have the port clk_100Hz, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have the port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The module SHALL have the port clr_flag, input, 1 bit: synchronous clear of all counts and the lap state.
REQ-006 The module SHALL have the port en, input, 1 bit: count enable (run/stop).
REQ-007 The module SHALL have the port carry_1s, input, 1 bit: upstream centisecond counter at 99; combinational, level.
REQ-008 The module SHALL have the port cnt_cs, input, 8 bits: upstream BCD centisecond value {tens,units}.
REQ-009 The module SHALL have the port lap_key, input, 1 bit: debounced lap/hold key, level, active-high.
REQ-010 The module SHALL have the port cnt_s, output, 8 bits: live BCD seconds, 00-59.
REQ-011 The module SHALL have the port cnt_m, output, 8 bits: live BCD minutes, 00-59.
REQ-012 The module SHALL have the port carry_1h, output, 1 bit: combinational, high while the live time is 59:59.99, carry_1s=1 and en=1.
REQ-013 The module SHALL have the ports disp_m, disp_s and disp_cs, outputs, 8 bits each: the displayed BCD time, either live or held lap.
REQ-014 The module SHALL have the port hold, output, 1 bit: 1 while the display shows the held lap value.

Function
REQ-015 The second counter SHALL advance on a clock edge only when en=1 and carry_1s=1.
  - This is the same edge on which the upstream counter wraps 99->00.
REQ-016 The BCD units digit SHALL count 0-9; on 9 with advance it SHALL go to 0 and the tens digit SHALL increment; tens SHALL count 0-5.
REQ-017 On cnt_s=SEC_MAX with advance, cnt_s SHALL go to 00 and cnt_m SHALL increment by one BCD step on the same edge.
REQ-018 On cnt_m=MIN_MAX and cnt_s=SEC_MAX with advance, both SHALL go to 00:00, carry_1h SHALL be high for that cycle, and there SHALL be no saturation.
REQ-019 With en=0, cnt_s and cnt_m SHALL hold regardless of carry_1s, and carry_1h SHALL be 0.
REQ-020 lap_key SHALL be registered once; a rising edge SHALL be detected as lap_key=1 while the registered value is 0, and each rising edge SHALL be one lap event.
REQ-021 A lap event with hold=0 SHALL capture {cnt_m, cnt_s, cnt_cs} as sampled on that edge into lap registers and set hold=1 on the next edge.
REQ-022 A lap event with hold=1 SHALL set hold=0; the lap registers SHALL keep their value.
REQ-023 While hold=1, disp_* SHALL equal the lap registers; while hold=0, disp_* SHALL equal the live {cnt_m, cnt_s, cnt_cs}, combinationally.
REQ-024 Counting SHALL continue unaffected while hold=1.
REQ-025 Lap events SHALL work with en=0.
REQ-026 clr_flag=1 SHALL take priority over advance and lap events on the same edge and SHALL zero cnt_s, cnt_m, the lap registers and hold.
REQ-027 A digit value above 9 (illegal BCD) SHALL be corrected to 0 on the next advance.

Reset
REQ-028 rst_n=0 SHALL immediately force cnt_s=00, cnt_m=00, lap registers=0, hold=0 and the lap_key register=0.
REQ-029 During reset, carry_1h SHALL be 0 and disp_* SHALL read 00.
REQ-030 After reset release, lap_key already high SHALL produce one lap event on the first edge.

Structure
REQ-031 A shared header SHALL hold the BCD limit constants (digit max 4'd9, tens max 4'd5) and the 8'h59 defaults.
REQ-032 One sub-module bcd_mod_cnt SHALL be used: a two-digit BCD modulo counter with inc, clr, terminal value and carry output, instantiated twice (seconds, minutes).

Verification
REQ-033 Reset then en=1 with carry_1s pulsed 60 times SHALL give cnt_s 00->59->00 and cnt_m=01.
REQ-034 State 59:58, en=1 with two carry_1s pulses SHALL give carry_1h=1 during the second pulse and 00:00 after it.
REQ-035 en=0 with 10 carry_1s pulses SHALL leave cnt_s and cnt_m unchanged.
REQ-036 Live 03:27.45 with a lap_key press SHALL give hold=1 and disp=03:27.45 while the live count keeps running; a second press SHALL give hold=0 and disp=live.
REQ-037 clr_flag and lap edge on the same edge at 12:34 with hold=1 SHALL give 00:00, hold=0 and lap registers=0.
REQ-038 rst_n asserted mid-count between edges SHALL zero the outputs immediately, without waiting for a clock edge.
